// File: rtl/field_pkg.sv
// Shared field-arithmetic definitions for the GF(2^255 - 19) datapath.
package field_pkg;
    localparam int N     = 255;
    localparam int CNT_W = $clog2(N);

    typedef logic [N-1:0] fe_t;

    // 2^255 - 19: all ones except the low five bits, which are 0b01101
    localparam fe_t P = {{(N-5){1'b1}}, 5'b01101};

    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
endpackage

// File: rtl/add_modp.sv
// Combinational a + b mod p for any two N-bit operands; result is canonical.
module add_modp
    import field_pkg::*;
(
    input  fe_t a,
    input  fe_t b,
    output fe_t sum
);
    logic [N:0]   s;
    logic [N:0]   t;
    fe_t          diff;
    logic         ge_p;

    // 2^255 = 19 (mod p): fold the carry back in, leaving t < p + 38
    assign s    = {1'b0, a} + {1'b0, b};
    assign t    = {1'b0, s[N-1:0]} + (s[N] ? (N+1)'(19) : '0);
    assign ge_p = (t >= {1'b0, P});
    assign diff = t[N-1:0] - P;
    assign sum  = ge_p ? diff : t[N-1:0];
endmodule

// File: rtl/mul_modp.sv
// Sequential x*y mod p, MSB-first double-and-add, one multiplier bit per cycle.
//   state | meaning
//   IDLE  | ready for a new operation (in_ready=1)
//   RUN   | one double-and-add step per cycle, cnt counts down to 0
//   DONE  | prod valid, held until out_ready
module mul_modp
    import field_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_valid,
    output logic   in_ready,
    input  fe_t    x,
    input  fe_t    y,
    output logic   out_valid,
    input  logic   out_ready,
    output fe_t    prod
);
    mul_state_t        state_q, state_d;
    fe_t               acc_q, acc_d;
    fe_t               x_q, x_d;
    fe_t               y_q, y_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    fe_t               dbl;
    fe_t               dbl_add;
    logic              cnt_tc;

    add_modp u_double (.a(acc_q), .b(acc_q), .sum(dbl));
    add_modp u_cond_add (.a(dbl), .b(x_q), .sum(dbl_add));

    assign cnt_tc = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (cnt_tc)    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        prod      = acc_q;
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        x_d   = x_q;
        y_d   = y_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d   = x;
                    y_d   = y;
                    acc_d = '0;
                    cnt_d = CNT_W'(N - 1);
                end
            end
            RUN: begin
                acc_d = y_q[cnt_q] ? dbl_add : dbl;
                if (!cnt_tc) cnt_d = cnt_q - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end
endmodule

// File: tb/tb_mul_modp.sv
// Directed-vector bench for mul_modp with hand-computed modular products.
module tb_mul_modp;
    localparam int W = 255;
    typedef logic [W-1:0] val_t;

    localparam val_t P_C = {{(W-5){1'b1}}, 5'b01101};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    val_t x = '0;
    val_t y = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    val_t prod;

    int n_checks = 0;
    int n_fail   = 0;

    mul_modp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input val_t obs, input val_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Present operands for one edge; caller is positioned #1 after an edge.
    task automatic start_op(input string tag, input val_t a, input val_t b);
        check({tag, "_in_ready"}, val_t'(in_ready), val_t'(1));
        x        = a;
        y        = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x        = '0;
        y        = '0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) break;
        end
        check({tag, "_latency"}, val_t'(n), val_t'(255));
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ov_after"}, val_t'(out_valid), val_t'(0));
        check({tag, "_ir_after"}, val_t'(in_ready), val_t'(1));
    endtask

    task automatic run_op(input string tag, input val_t a, input val_t b, input val_t exp);
        start_op(tag, a, b);
        wait_done(tag);
        check({tag, "_prod"}, prod, exp);
        consume(tag);
    endtask

    initial begin
        val_t a, b, held;
        int bad, hits;

        #12;
        check("rst_in_ready", val_t'(in_ready), val_t'(1));
        check("rst_out_valid", val_t'(out_valid), val_t'(0));
        check("rst_prod", prod, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("t3x5", val_t'(3), val_t'(5), val_t'(15));
        run_op("pm1sq", P_C - 1, P_C - 1, val_t'(1));
        a = '1;
        run_op("allones_x2", a, val_t'(2), val_t'(36));
        a = '0;
        a[254] = 1'b1;
        run_op("2p254_x2", a, val_t'(2), val_t'(19));
        b = '1;
        run_op("zero_x", '0, b, '0);
        run_op("p_x7", P_C, val_t'(7), '0);

        // Backpressure, with in_valid asserted to confirm it is ignored in DONE
        start_op("bp", val_t'(11), val_t'(13));
        wait_done("bp");
        check("bp_prod", prod, val_t'(143));
        held = prod;
        bad  = 0;
        x = val_t'(9);
        y = val_t'(9);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (!out_valid || in_ready || prod !== held) bad++;
        end
        in_valid = 1'b0;
        check("bp_stable_cycles_bad", val_t'(bad), '0);
        consume("bp");
        run_op("b2b_2x3", val_t'(2), val_t'(3), val_t'(6));

        // Reset in cycle 100 of RUN discards the operation
        start_op("rst_mid", val_t'(5), val_t'(5));
        repeat (99) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", val_t'(out_valid), val_t'(0));
        check("midrst_in_ready", val_t'(in_ready), val_t'(1));
        check("midrst_prod", prod, '0);
        @(negedge clk);
        rst_n = 1'b1;
        hits = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) hits++;
        end
        check("midrst_no_result", val_t'(hits), '0);
        run_op("t7x9", val_t'(7), val_t'(9), val_t'(63));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
